// File: rtl/npc_pkg.sv
// Shared state codes, access-width codes and reset constants for the NPC multi-cycle controller.
// The optional bus watchdog in npc_mc_ctrl is enabled with NPC_BUS_TIMEOUT_EN.
package npc_pkg;

  typedef logic [2:0] npc_state_t;

  localparam npc_state_t S_FETCH_REQ  = 3'd0;
  localparam npc_state_t S_FETCH_WAIT = 3'd1;
  localparam npc_state_t S_EXEC       = 3'd2;
  localparam npc_state_t S_MEM_REQ    = 3'd3;
  localparam npc_state_t S_MEM_WAIT   = 3'd4;
  localparam npc_state_t S_WB         = 3'd5;
  localparam npc_state_t S_HALT       = 3'd6;
  localparam npc_state_t S_ERR        = 3'd7;

  typedef enum logic [1:0] {
    W_BYTE   = 2'd0,
    W_HALF   = 2'd1,
    W_WORD   = 2'd2,
    W_DOUBLE = 2'd3
  } npc_width_e;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/npc_wmask.sv
// Byte-enable generator and store-data lane shifter: places an access of the given
// width at the byte offset given by the low address bits.
module npc_wmask
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                 width,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [XLEN-1:0]            wdata,
  output logic [XLEN/8-1:0]          wmask,
  output logic [XLEN-1:0]            wdata_lane
);

  localparam int NB = XLEN / 8;

  logic [4:0] len;

  always_comb begin
    case (npc_width_e'(width))
      W_BYTE:  len = 5'd1;
      W_HALF:  len = 5'd2;
      W_WORD:  len = 5'd4;
      default: len = 5'd8;
    endcase
  end

  // Lane gi is enabled when it falls inside [off, off+len); lanes past the top are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign wmask[gi] = (5'(gi) >= 5'(off)) && ((5'(gi) - 5'(off)) < len);
    end
  endgenerate

  assign wdata_lane = wdata << {off, 3'b000};

endmodule

// File: rtl/npc_mc_ctrl.sv
// Multi-cycle NPC sequencer: owns pc/inst and steps fetch, execute, memory and writeback
// over valid/ready buses. Define NPC_BUS_TIMEOUT_EN to enable the bus watchdog (ERR state).
module npc_mc_ctrl
  import npc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_resp_valid,
  input  logic [31:0]         imem_rdata,
  output logic [XLEN-1:0]     pc,
  output logic [31:0]         inst,
  input  logic                dec_is_load,
  input  logic                dec_is_store,
  input  logic                dec_wen,
  input  logic                dec_halt,
  input  logic [1:0]          ex_width,
  input  logic [XLEN-1:0]     ex_addr,
  input  logic [XLEN-1:0]     ex_wdata,
  input  logic                ex_jmp_flag,
  input  logic [XLEN-1:0]     ex_jmp_addr,
  output logic                dmem_req_valid,
  input  logic                dmem_req_ready,
  output logic                dmem_we,
  output logic [XLEN-1:0]     dmem_addr,
  output logic [XLEN-1:0]     dmem_wdata,
  output logic [XLEN/8-1:0]   dmem_wmask,
  input  logic                dmem_resp_valid,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic [XLEN-1:0]     load_data,
  output logic                rf_wen,
  output logic                commit,
  output logic                halted,
  output logic                bus_err
);

  npc_state_t        state_reg, state_next;
  logic [XLEN-1:0]   pc_reg;
  logic [31:0]       inst_reg;
  logic [XLEN-1:0]   load_data_reg;
  logic [XLEN/8-1:0] lane_mask;
  logic              bus_wait;

  assign bus_wait = (state_reg == S_FETCH_REQ) || (state_reg == S_FETCH_WAIT) ||
                    (state_reg == S_MEM_REQ)   || (state_reg == S_MEM_WAIT);

`ifdef NPC_BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CNT_W-1:0] tmo_cnt_reg;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH_REQ:  if (imem_req_ready)  state_next = S_FETCH_WAIT;
      S_FETCH_WAIT: if (imem_resp_valid) state_next = S_EXEC;
      S_EXEC: begin
        if (dec_halt)                          state_next = S_HALT;
        else if (dec_is_load || dec_is_store)  state_next = S_MEM_REQ;
        else                                   state_next = S_WB;
      end
      S_MEM_REQ:    if (dmem_req_ready)  state_next = S_MEM_WAIT;
      S_MEM_WAIT:   if (dmem_resp_valid) state_next = S_WB;
      S_WB:         state_next = S_FETCH_REQ;
      default:      state_next = state_reg;
    endcase
`ifdef NPC_BUS_TIMEOUT_EN
    // A handshake completing on the last allowed cycle still wins over the watchdog.
    if (bus_wait && (state_next == state_reg) && (tmo_cnt_reg == CNT_W'(TIMEOUT - 1)))
      state_next = S_ERR;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_FETCH_REQ;
      pc_reg        <= RESET_PC;
      inst_reg      <= NOP;
      load_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == S_FETCH_WAIT) && imem_resp_valid)
        inst_reg <= imem_rdata;
      if ((state_reg == S_MEM_WAIT) && dmem_resp_valid && dec_is_load)
        load_data_reg <= dmem_rdata;
      if (state_reg == S_WB)
        pc_reg <= (ex_jmp_flag ? ex_jmp_addr : pc_reg + XLEN'(4)) & ~XLEN'(3);
    end
  end

`ifdef NPC_BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || (state_next != state_reg) || !bus_wait)
      tmo_cnt_reg <= '0;
    else
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
  end

  assign bus_err = (state_reg == S_ERR);
`else
  assign bus_err = (TIMEOUT < 0);
`endif

  npc_wmask #(
    .XLEN (XLEN)
  ) u_wmask (
    .width      (ex_width),
    .off        (ex_addr[$clog2(XLEN/8)-1:0]),
    .wdata      (ex_wdata),
    .wmask      (lane_mask),
    .wdata_lane (dmem_wdata)
  );

  assign imem_req_valid = (state_reg == S_FETCH_REQ);
  assign imem_addr      = pc_reg;
  assign pc             = pc_reg;
  assign inst           = inst_reg;
  assign dmem_req_valid = (state_reg == S_MEM_REQ);
  assign dmem_we        = (state_reg == S_MEM_REQ) && dec_is_store;
  assign dmem_addr      = ex_addr;
  assign dmem_wmask     = (state_reg == S_MEM_REQ) ? lane_mask : '0;
  assign load_data      = load_data_reg;
  assign commit         = (state_reg == S_WB);
  assign rf_wen         = (state_reg == S_WB) && dec_wen && !dec_is_store;
  assign halted         = (state_reg == S_HALT);

endmodule

// File: tb/tb_npc_mc_ctrl.sv
// Directed bench for npc_mc_ctrl (XLEN=32): bus handshakes are driven per cycle with
// configurable wait states and results are compared against hand-computed values.
module tb_npc_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_addr, imem_rdata, pc, inst;
  logic        dec_is_load, dec_is_store, dec_wen, dec_halt;
  logic [1:0]  ex_width;
  logic [31:0] ex_addr, ex_wdata, ex_jmp_addr;
  logic        ex_jmp_flag;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_resp_valid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
  logic [3:0]  dmem_wmask;
  logic        rf_wen, commit, halted, bus_err;

  int n_vec = 0;
  int n_err = 0;
  int stray = 0;
  int hold_err = 0;

  always #5 clk = ~clk;

  npc_mc_ctrl #(
    .XLEN    (32),
    .TIMEOUT (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_rdata      (imem_rdata),
    .pc              (pc),
    .inst            (inst),
    .dec_is_load     (dec_is_load),
    .dec_is_store    (dec_is_store),
    .dec_wen         (dec_wen),
    .dec_halt        (dec_halt),
    .ex_width        (ex_width),
    .ex_addr         (ex_addr),
    .ex_wdata        (ex_wdata),
    .ex_jmp_flag     (ex_jmp_flag),
    .ex_jmp_addr     (ex_jmp_addr),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_wmask      (dmem_wmask),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_rdata      (dmem_rdata),
    .load_data       (load_data),
    .rf_wen          (rf_wen),
    .commit          (commit),
    .halted          (halted),
    .bus_err         (bus_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_inst(input logic [31:0] rdata, input logic ld, input logic st,
                          input logic wen, input logic hlt, input logic [1:0] w,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic jf, input logic [31:0] ja, input logic [31:0] rd);
    imem_rdata   = rdata;
    dec_is_load  = ld;
    dec_is_store = st;
    dec_wen      = wen;
    dec_halt     = hlt;
    ex_width     = w;
    ex_addr      = addr;
    ex_wdata     = wd;
    ex_jmp_flag  = jf;
    ex_jmp_addr  = ja;
    dmem_rdata   = rd;
  endtask

  // Runs one instruction from FETCH_REQ (cycle 1) until commit; cyc=0 if it never commits.
  task automatic run_inst(input int ird, input int irsp, input int drd, input int drsp,
                          output int cyc, output logic rfw, output logic [3:0] mask,
                          output logic [31:0] wd, output logic we, output logic [31:0] iaddr);
    int f_cnt, f_cd, d_cnt, d_cd;
    f_cnt = 0; f_cd = -1; d_cnt = 0; d_cd = -1;
    cyc = 0; rfw = 1'b0; mask = '0; wd = '0; we = 1'b0; iaddr = '0;
    for (int c = 1; c <= 60 && cyc == 0; c++) begin
      if (c == 1) iaddr = imem_addr;
      if (imem_req_valid && (imem_addr !== iaddr)) hold_err++;
      imem_req_ready = imem_req_valid && (f_cnt >= ird);
      if (imem_req_valid && !imem_req_ready) f_cnt++;
      imem_resp_valid = (f_cd == 0);
      dmem_req_ready = dmem_req_valid && (d_cnt >= drd);
      if (dmem_req_valid && !dmem_req_ready) d_cnt++;
      dmem_resp_valid = (d_cd == 0);
      if (dmem_req_valid) begin
        mask = dmem_wmask;
        wd   = dmem_wdata;
        we   = dmem_we;
      end
      if (rf_wen && !commit) stray++;
      if (commit) begin
        cyc = c;
        rfw = rf_wen;
      end
      if (f_cd >= 0) f_cd--;
      if (d_cd >= 0) d_cd--;
      if (imem_req_ready) f_cd = irsp;
      if (dmem_req_ready) d_cd = drsp;
      @(posedge clk); #1;
    end
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
  endtask

  int          cyc;
  logic        rfw, we;
  logic [3:0]  mask;
  logic [31:0] wd, iaddr;
  int          busy;

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    set_inst(32'h0, 0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_load_data", load_data, 32'h0);
    check("rst_imem_valid", imem_req_valid, 1'b1);
    check("rst_dmem_valid", dmem_req_valid, 1'b0);
    check("rst_dmem_we", dmem_we, 1'b0);
    check("rst_wmask", dmem_wmask, 4'h0);
    check("rst_commit", commit, 1'b0);
    check("rst_rf_wen", rf_wen, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    rst = 1'b0;

    // addi x1, x0, 1 at RESET_PC, zero-wait memories
    set_inst(32'h0010_0093, 0, 0, 1, 0, 2'd2, 32'h1, 32'h0, 0, 32'h0, 32'h0);
    run_inst(0, 0, 0, 0, cyc, rfw, mask, wd, we, iaddr);
    $display("addi: cycles=%0d rf_wen=%0b pc=%08h", cyc, rfw, pc);
    check("addi_imem_addr", iaddr, 32'h8000_0000);
    check("addi_cycles", cyc, 4);
    check("addi_rf_wen", rfw, 1'b1);
    check("addi_inst", inst, 32'h0010_0093);
    check("addi_pc", pc, 32'h8000_0004);

    // jal to an unaligned target: low bits forced to zero
    set_inst(32'h0fc0_00ef, 0, 0, 1, 0, 2'd2, 32'h0, 32'h0, 1, 32'h8000_0102, 32'h0);
    run_inst(0, 0, 0, 0, cyc, rfw, mask, wd, we, iaddr);
    $display("jal: cycles=%0d pc=%08h", cyc, pc);
    check("jal_cycles", cyc, 4);
    check("jal_pc", pc, 32'h8000_0100);

    // lw with 3 fetch-ready stalls and 2 extra data response cycles
    set_inst(32'h0000_a103, 1, 0, 1, 0, 2'd2, 32'h8000_2000, 32'h0, 0, 32'h0, 32'hdead_beef);
    run_inst(3, 0, 0, 2, cyc, rfw, mask, wd, we, iaddr);
    $display("lw: cycles=%0d load_data=%08h mask=%b we=%0b", cyc, load_data, mask, we);
    check("lw_imem_addr", iaddr, 32'h8000_0100);
    check("lw_cycles", cyc, 11);
    check("lw_load_data", load_data, 32'hdead_beef);
    check("lw_rf_wen", rfw, 1'b1);
    check("lw_wmask", mask, 4'b1111);
    check("lw_we", we, 1'b0);
    check("lw_pc", pc, 32'h8000_0104);

    // sb to byte lane 3; dec_wen held high to show stores never write rd
    set_inst(32'h00b0_01a3, 0, 1, 1, 0, 2'd0, 32'h8000_1003, 32'h0000_00ab, 0, 32'h0, 32'h1111_1111);
    run_inst(0, 0, 0, 0, cyc, rfw, mask, wd, we, iaddr);
    $display("sb: cycles=%0d mask=%b wdata=%08h we=%0b", cyc, mask, wd, we);
    check("sb_cycles", cyc, 6);
    check("sb_wmask", mask, 4'b1000);
    check("sb_wdata", wd, 32'hab00_0000);
    check("sb_we", we, 1'b1);
    check("sb_rf_wen", rfw, 1'b0);
    check("sb_load_data_kept", load_data, 32'hdead_beef);
    check("sb_pc", pc, 32'h8000_0108);

    // sh to the upper half-word
    set_inst(32'h00b0_1123, 0, 1, 0, 0, 2'd1, 32'h8000_1002, 32'h0000_1234, 0, 32'h0, 32'h0);
    run_inst(0, 0, 0, 0, cyc, rfw, mask, wd, we, iaddr);
    $display("sh: cycles=%0d mask=%b wdata=%08h", cyc, mask, wd);
    check("sh_cycles", cyc, 6);
    check("sh_wmask", mask, 4'b1100);
    check("sh_wdata", wd, 32'h1234_0000);
    check("sh_pc", pc, 32'h8000_010c);
    check("no_stray_rf_wen", stray, 0);
    check("imem_addr_hold", hold_err, 0);

    // ebreak: halts after EXEC and stays quiet
    set_inst(32'h0010_0073, 0, 0, 0, 1, 2'd0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1;
    @(posedge clk); #1;
    imem_resp_valid = 1'b0;
    @(posedge clk); #1;
    check("ebreak_halted", halted, 1'b1);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      imem_req_ready = 1'b1; dmem_req_ready = 1'b1;
      if (imem_req_valid || dmem_req_valid || commit || !halted) busy++;
      @(posedge clk); #1;
    end
    imem_req_ready = 1'b0; dmem_req_ready = 1'b0;
    $display("ebreak: halted=%0b busy_cycles=%0d pc=%08h", halted, busy, pc);
    check("halt_quiet", busy, 0);
    check("halt_pc", pc, 32'h8000_010c);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("halt_rst_pc", pc, 32'h8000_0000);
    check("halt_rst_halted", halted, 1'b0);

    // reset while a fetch is outstanding
    set_inst(32'h0010_0093, 0, 0, 1, 0, 2'd2, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    run_inst(0, 0, 0, 0, cyc, rfw, mask, wd, we, iaddr);
    check("midrst_pre_pc", pc, 32'h8000_0004);
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("midrst: pc=%08h inst=%08h imem_req_valid=%0b", pc, inst, imem_req_valid);
    check("midrst_pc", pc, 32'h8000_0000);
    check("midrst_inst", inst, 32'h0000_0013);
    check("midrst_imem_valid", imem_req_valid, 1'b1);

`ifdef NPC_BUS_TIMEOUT_EN
    // imem_req_ready stuck low: 8 cycles in FETCH_REQ, then ERR
    for (int c = 1; c <= 9; c++) begin
      if (c == 8) begin
        check("tmo_before_err", bus_err, 1'b0);
        check("tmo_before_valid", imem_req_valid, 1'b1);
      end
      if (c == 9) begin
        check("tmo_err", bus_err, 1'b1);
        check("tmo_err_valid", imem_req_valid, 1'b0);
      end
      if (c < 9) begin
        @(posedge clk); #1;
      end
    end
    repeat (10) @(posedge clk);
    #1;
    check("tmo_sticky", bus_err, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("tmo_rst_clear", bus_err, 1'b0);
    $display("timeout: bus_err cleared by rst=%0b", !bus_err);
`else
    // without the watchdog a stuck bus simply waits
    repeat (20) @(posedge clk);
    #1;
    $display("stuck bus: bus_err=%0b imem_req_valid=%0b", bus_err, imem_req_valid);
    check("stuck_no_err", bus_err, 1'b0);
    check("stuck_still_req", imem_req_valid, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
